// File: rtl/cache_arb_pkg.sv
// Shared types for the cache front-end arbiter: FSM states, port identifiers, counter width.
// Optional round-robin tie-break is selected with the ARB_ROUND_ROBIN_EN macro.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  localparam int WAIT_W = 16;

endpackage

// File: rtl/cache_arbiter_pick.sv
// Combinational winner selection between the I and D request ports.
// ARB_ROUND_ROBIN_EN defined: ties go to the port not granted last; otherwise D wins ties.
module arb_pick
  import cache_arb_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_port_t last_grant,
  output logic      grant_valid,
  output arb_port_t grant_port
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_port  = PORT_D;
    if (i_req && !d_req) begin
      grant_port = PORT_I;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (i_req && d_req && (last_grant == PORT_D)) begin
      grant_port = PORT_I;
    end
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; the port exists so both builds share one interface.
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == PORT_D);
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Merges the I-fetch and D ports onto the single cache CPU port, one transaction at a time.
// Build option ARB_ROUND_ROBIN_EN switches tie-breaking from fixed D priority to round-robin.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              i_done,
  output logic [DW-1:0]     i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_done,
  output logic [DW-1:0]     d_rdata,
  output logic              c_ready,
  output logic              c_write,
  output logic [AW-1:0]     c_addr,
  output logic [DW-1:0]     c_data,
  input  logic              c_hit,
  input  logic [DW-1:0]     c_out,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              timeout
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);

  arb_state_t        state_q, state_d;
  arb_port_t         owner_q, owner_d;
  logic              c_write_q, c_write_d;
  logic [AW-1:0]     c_addr_q, c_addr_d;
  logic [DW-1:0]     c_data_q, c_data_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [DW-1:0]     i_rdata_q, i_rdata_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic      grant_valid;
  arb_port_t grant_port;
  arb_port_t last_grant;

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_t last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) && grant_valid) begin
      last_grant_d = grant_port;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= PORT_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = PORT_I;
`endif

  arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    c_write_d  = c_write_q;
    c_addr_d   = c_addr_q;
    c_data_d   = c_data_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    i_done_d   = 1'b0;
    d_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = BUSY;
          owner_d = grant_port;
          if (grant_port == PORT_D) begin
            c_write_d = d_write;
            c_addr_d  = d_addr;
            c_data_d  = d_wdata;
          end else begin
            c_write_d = 1'b0;
            c_addr_d  = i_addr;
            c_data_d  = '0;
          end
        end
      end
      BUSY: begin
        if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // Only a cycle that ends without a hit counts towards the timeout.
        if (!c_hit && (wait_cnt_d >= MAX_WAIT_W)) begin
          timeout_d = 1'b1;
        end
        if (c_hit) begin
          state_d = RESP;
          if (owner_q == PORT_D) begin
            d_rdata_d = c_out;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = c_out;
            i_done_d  = 1'b1;
          end
        end
      end
      RESP: begin
        // No grant here, so a requester can swap in its next address this cycle.
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= PORT_I;
      c_write_q  <= 1'b0;
      c_addr_q   <= '0;
      c_data_q   <= '0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      c_write_q  <= c_write_d;
      c_addr_q   <= c_addr_d;
      c_data_q   <= c_data_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign c_ready  = (state_q == BUSY);
  assign c_write  = c_write_q;
  assign c_addr   = c_addr_q;
  assign c_data   = c_data_q;
  assign i_done   = i_done_q;
  assign d_done   = d_done_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign wait_cnt = wait_cnt_q;
  assign timeout  = timeout_q;

endmodule
